// File: rtl/morph_frame_ctrl_if.sv
// Pixel-path bundle for morph_frame_ctrl: source stream, window block link and aligned output stream.
// The controller uses the slave modport; the surrounding source/window/consumer side uses master.
interface morph_frame_ctrl_if #(
  parameter int unsigned N = 1
);
  logic         in_valid;
  logic [N-1:0] in_pixel;
  logic         win_rst_n;
  logic         win_read;
  logic [N-1:0] win_pi;
  logic         win_valid;
  logic [N-1:0] win_pixel;
  logic         out_valid;
  logic [N-1:0] out_pixel;
  logic         out_sof;
  logic         out_eol;

  modport master (
    output in_valid, in_pixel, win_valid, win_pixel,
    input  win_rst_n, win_read, win_pi, out_valid, out_pixel, out_sof, out_eol
  );

  modport slave (
    input  in_valid, in_pixel, win_valid, win_pixel,
    output win_rst_n, win_read, win_pi, out_valid, out_pixel, out_sof, out_eol
  );
endinterface

// File: rtl/morph_frame_ctrl.sv
// Frame sequencer for the 3x3 morphology window: clears the window, feeds a W*H frame plus W+1 pad
// pixels, drops fill latency and emits W*H aligned pixels. Optional macro BORDER_MASK_EN masks frame edges.
module morph_frame_ctrl #(
  parameter int unsigned    N          = 1,
  parameter logic [N-1:0]   PAD_VALUE  = '0,
  parameter logic [N-1:0]   BORDER_VAL = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [15:0]          img_width,
  input  logic [15:0]          img_height,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err,
  output logic                 drop_err,
  morph_frame_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, FLUSH, DRAIN} state_t;

  state_t       state_q, state_d;
  logic [15:0]  w_q, h_q;
  logic [31:0]  total_q;
  logic [31:0]  in_cnt_q;
  logic [16:0]  flush_cnt_q;
  logic [16:0]  skip_q;
  logic [31:0]  out_cnt_q;
  logic [15:0]  col_q, row_q;
  logic         cfg_ok;
  logic         active;
  logic         fwd;

  assign cfg_ok = (img_width >= 16'd3) && (img_height >= 16'd1);
  assign active = (state_q == RUN) || (state_q == FLUSH) || (state_q == DRAIN);
  assign fwd    = bus.win_valid && active && (skip_q == ({1'b0, w_q} + 17'd1)) &&
                  (out_cnt_q < total_q);

  assign busy          = (state_q != IDLE);
  assign bus.win_rst_n = ~(reset | (state_q == CLEAR));

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    bus.win_read = 1'b0;
    bus.win_pi   = '0;
    case (state_q)
      IDLE:  if (start && cfg_ok) state_d = CLEAR;
      CLEAR: state_d = RUN;
      RUN: begin
        bus.win_read = bus.in_valid;
        bus.win_pi   = bus.in_pixel;
        if (bus.in_valid && (in_cnt_q + 32'd1 == total_q)) state_d = FLUSH;
      end
      FLUSH: begin
        bus.win_read = 1'b1;
        bus.win_pi   = PAD_VALUE;
        if (flush_cnt_q == {1'b0, w_q}) state_d = DRAIN;
      end
      DRAIN: if (out_cnt_q == total_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Keep the window strobe quiet while reset is held, even if the state has not yet returned to IDLE.
    if (reset) begin
      bus.win_read = 1'b0;
      bus.win_pi   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_q           <= '0;
      h_q           <= '0;
      total_q       <= '0;
      in_cnt_q      <= '0;
      flush_cnt_q   <= '0;
      skip_q        <= '0;
      out_cnt_q     <= '0;
      col_q         <= '0;
      row_q         <= '0;
      done          <= 1'b0;
      cfg_err       <= 1'b0;
      drop_err      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_pixel <= '0;
      bus.out_sof   <= 1'b0;
      bus.out_eol   <= 1'b0;
    end else begin
      done          <= (state_q == DRAIN) && (state_d == IDLE);
      cfg_err       <= (state_q == IDLE) && start && !cfg_ok;
      drop_err      <= bus.in_valid && (state_q != RUN);
      bus.out_valid <= fwd;
      bus.out_sof   <= 1'b0;
      bus.out_eol   <= 1'b0;

      if (state_q == IDLE && start && cfg_ok) begin
        w_q <= img_width;
        h_q <= img_height;
      end

      if (state_q == CLEAR) begin
        total_q     <= 32'(w_q) * 32'(h_q);
        in_cnt_q    <= '0;
        flush_cnt_q <= '0;
        skip_q      <= '0;
        out_cnt_q   <= '0;
        col_q       <= '0;
        row_q       <= '0;
      end else begin
        if (state_q == RUN && bus.in_valid) in_cnt_q <= in_cnt_q + 32'd1;
        if (state_q == FLUSH) flush_cnt_q <= flush_cnt_q + 17'd1;
        if (bus.win_valid && active && (skip_q < ({1'b0, w_q} + 17'd1)))
          skip_q <= skip_q + 17'd1;
        if (fwd) begin
          out_cnt_q   <= out_cnt_q + 32'd1;
          bus.out_sof <= (row_q == 16'd0) && (col_q == 16'd0);
          bus.out_eol <= (col_q == w_q - 16'd1);
`ifdef BORDER_MASK_EN
          if (row_q == 16'd0 || row_q == h_q - 16'd1 || col_q == 16'd0 || col_q == w_q - 16'd1)
            bus.out_pixel <= BORDER_VAL;
          else
            bus.out_pixel <= bus.win_pixel;
`else
          bus.out_pixel <= bus.win_pixel;
`endif
          if (col_q == w_q - 16'd1) begin
            col_q <= '0;
            row_q <= row_q + 16'd1;
          end else begin
            col_q <= col_q + 16'd1;
          end
        end
      end
    end
  end

`ifndef BORDER_MASK_EN
  logic border_unused;
  assign border_unused = ^BORDER_VAL;
`endif

endmodule

// File: tb/tb_morph_frame_ctrl.sv
// Directed bench for morph_frame_ctrl with a center-tap window model (output = pixel read W+1 reads earlier).
// Honors BORDER_MASK_EN in its expectations.
module tb_morph_frame_ctrl;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] img_width = '0;
  logic [15:0] img_height = '0;
  logic        start = 1'b0;
  logic        busy, done, cfg_err, drop_err;

  morph_frame_ctrl_if #(.N(4)) bus ();

  morph_frame_ctrl #(.N(4), .PAD_VALUE(4'h0), .BORDER_VAL(4'h0)) dut (
    .clock(clock), .reset(reset), .img_width(img_width), .img_height(img_height),
    .start(start), .busy(busy), .done(done), .cfg_err(cfg_err), .drop_err(drop_err),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int total_cnt = 0;
  int bad_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Window model: one output beat per read, carrying the pixel read W+1 reads earlier.
  int          wm = 4;
  logic [3:0]  sr [64];
  always @(posedge clock) begin
    if (!bus.win_rst_n) begin
      bus.win_valid <= 1'b0;
      bus.win_pixel <= '0;
      for (int i = 0; i < 64; i++) sr[i] <= '0;
    end else begin
      bus.win_valid <= bus.win_read;
      if (bus.win_read) begin
        bus.win_pixel <= sr[wm];
        for (int i = 63; i > 0; i--) sr[i] <= sr[i-1];
        sr[0] <= bus.win_pi;
      end
    end
  end

  int nbeat = 0, npad = 0, nclr = 0, ndone = 0, nbusydone = 0, ncfg = 0, ndrop = 0;
  logic [3:0] lpix [256];
  logic       lsof [256];
  logic       leol [256];
  always @(negedge clock) begin
    if (bus.out_valid) begin
      if (nbeat < 256) begin
        lpix[nbeat] = bus.out_pixel;
        lsof[nbeat] = bus.out_sof;
        leol[nbeat] = bus.out_eol;
      end
      nbeat++;
    end
    if (bus.win_read && !bus.in_valid) npad++;
    if (!bus.win_rst_n) nclr++;
    if (done) begin
      ndone++;
      if (busy) nbusydone++;
    end
    if (cfg_err) ncfg++;
    if (drop_err) ndrop++;
  end

  function automatic logic [3:0] pat(input int mode, input int k);
    logic [3:0] v;
    v = (mode == 0) ? 4'((k % 15) + 1) : 4'hF;
    return v;
  endfunction

  function automatic logic [3:0] exp_pix(input int mode, input int k, input int w, input int h);
`ifdef BORDER_MASK_EN
    if ((k / w) == 0 || (k / w) == h - 1 || (k % w) == 0 || (k % w) == w - 1) return 4'h0;
`endif
    return pat(mode, k);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_frame(input string nm, input int w, input int h, input int gap,
                           input int mode, input bit restart);
    int b, p, c, d, bd, cf, dr, guard;
    wm = w;
    b = nbeat; p = npad; c = nclr; d = ndone; bd = nbusydone; cf = ncfg; dr = ndrop;
    img_width = 16'(w); img_height = 16'(h); start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < w * h; i++) begin
      bus.in_valid = 1'b1;
      bus.in_pixel = pat(mode, i);
      start = restart && (i == 5);
      tick();
      bus.in_valid = 1'b0;
      start = 1'b0;
      repeat (gap) tick();
    end
    guard = 0;
    while (ndone == d && guard < 1000) begin
      tick();
      guard++;
    end
    check({nm, ".timeout"}, 32'(guard < 1000), 32'd1);
    repeat (4) tick();
    check({nm, ".beats"}, 32'(nbeat - b), 32'(w * h));
    check({nm, ".pads"}, 32'(npad - p), 32'(w + 1));
    check({nm, ".done_cnt"}, 32'(ndone - d), 32'd1);
    check({nm, ".busy_at_done"}, 32'(nbusydone - bd), 32'd0);
    check({nm, ".clear_cnt"}, 32'(nclr - c), 32'd1);
    check({nm, ".cfg_err_cnt"}, 32'(ncfg - cf), 32'd0);
    check({nm, ".drop_cnt"}, 32'(ndrop - dr), 32'd0);
    for (int k = 0; k < w * h && b + k < 256; k++) begin
      check($sformatf("%s.pix%0d", nm, k), 32'(lpix[b+k]), 32'(exp_pix(mode, k, w, h)));
      check($sformatf("%s.sof%0d", nm, k), 32'(lsof[b+k]), 32'(k == 0));
      check($sformatf("%s.eol%0d", nm, k), 32'(leol[b+k]), 32'((k % w) == w - 1));
    end
  endtask

  initial begin
    int c0, e0, d0;
    bus.in_valid = 1'b0;
    bus.in_pixel = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.win_read", 32'(bus.win_read), 32'd0);
    check("rst.win_rst_n", 32'(bus.win_rst_n), 32'd1);

    run_frame("s1", 4, 3, 0, 0, 1'b0);
    run_frame("s2", 4, 3, 2, 0, 1'b0);

    // Rejected configuration, then a stray pixel in IDLE.
    c0 = nclr; e0 = ncfg;
    img_width = 16'd2; img_height = 16'd5; start = 1'b1;
    tick();
    start = 1'b0;
    check("s3.cfg_err", 32'(cfg_err), 32'd1);
    check("s3.busy", 32'(busy), 32'd0);
    repeat (3) tick();
    check("s3.cfg_cnt", 32'(ncfg - e0), 32'd1);
    check("s3.clear_cnt", 32'(nclr - c0), 32'd0);
    d0 = ndrop;
    bus.in_valid = 1'b1;
    bus.in_pixel = 4'h5;
    #1;
    check("s3.win_read", 32'(bus.win_read), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    check("s3.drop_err", 32'(drop_err), 32'd1);
    repeat (3) tick();
    check("s3.drop_cnt", 32'(ndrop - d0), 32'd1);

    run_frame("s4", 8, 4, 0, 1, 1'b0);

    // Reset after 6 of 12 pixels.
    wm = 4;
    img_width = 16'd4; img_height = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_pixel = pat(0, i);
      tick();
    end
    bus.in_valid = 1'b0;
    reset = 1'b1;
    tick();
    check("s5.busy", 32'(busy), 32'd0);
    check("s5.done", 32'(done), 32'd0);
    check("s5.cfg_err", 32'(cfg_err), 32'd0);
    check("s5.drop_err", 32'(drop_err), 32'd0);
    check("s5.out_valid", 32'(bus.out_valid), 32'd0);
    check("s5.out_pixel", 32'(bus.out_pixel), 32'd0);
    check("s5.out_sof", 32'(bus.out_sof), 32'd0);
    check("s5.out_eol", 32'(bus.out_eol), 32'd0);
    check("s5.win_read", 32'(bus.win_read), 32'd0);
    check("s5.win_pi", 32'(bus.win_pi), 32'd0);
    check("s5.win_rst_n", 32'(bus.win_rst_n), 32'd0);
    reset = 1'b0;
    repeat (2) tick();
    run_frame("s5b", 4, 3, 0, 0, 1'b0);

    run_frame("s6", 4, 3, 0, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
